riscv_run_ctrl: RTL and testbench

Run-control block for the single-cycle RISC-V simulation environment. It generates a stretched, registered core reset from the external asynchronous reset and counts executed cycles. It detects program end (ECALL, EBREAK, or a PC self-loop) and flags a cycle-budget timeout, replacing fixed-delay reset and finish sequencing. It sits between the top-level clock/reset and `riscv_datapath`, and observes the datapath's PC and fetched instruction.

---
 rtl/riscv_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// Run control for the single-cycle RISC-V model: stretched core reset, RUN cycle
// counter, program-end detection (ECALL, EBREAK, PC self-loop) and cycle-budget timeout.
module riscv_run_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             a_rstn,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  output logic             core_rstn_o,
  output logic             running_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [1:0]       halt_reason_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT);

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] REASON_NONE   = 2'b00;
  localparam logic [1:0] REASON_ECALL  = 2'b01;
  localparam logic [1:0] REASON_EBREAK = 2'b10;
  localparam logic [1:0] REASON_LOOP   = 2'b11;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'b00,
    RUN        = 2'b01,
    HALTED     = 2'b10,
    TIMEOUT    = 2'b11
  } state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic               core_rstn_nxt;
  logic               running_nxt;
  logic               halted_nxt;
  logic               timeout_nxt;
  logic [1:0]         halt_reason_nxt;
  logic [CNT_W-1:0]   cycle_cnt_nxt;
  logic [XLEN-1:0]    prev_pc, prev_pc_nxt;
  logic               pc_valid, pc_valid_nxt;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_nxt;
  logic               pc_same;

  // State and output registers; everything returns to reset values the moment a_rstn drops
  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state         <= RESET_HOLD;
      hold_cnt      <= '0;
      core_rstn_o   <= 1'b0;
      running_o     <= 1'b0;
      halted_o      <= 1'b0;
      timeout_o     <= 1'b0;
      halt_reason_o <= REASON_NONE;
      cycle_cnt_o   <= '0;
      prev_pc       <= '0;
      pc_valid      <= 1'b0;
      rep_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_cnt_nxt;
      core_rstn_o   <= core_rstn_nxt;
      running_o     <= running_nxt;
      halted_o      <= halted_nxt;
      timeout_o     <= timeout_nxt;
      halt_reason_o <= halt_reason_nxt;
      cycle_cnt_o   <= cycle_cnt_nxt;
      prev_pc       <= prev_pc_nxt;
      pc_valid      <= pc_valid_nxt;
      rep_cnt       <= rep_cnt_nxt;
    end
  end

  // Next-state logic; terminal states simply keep every register as it is
  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    core_rstn_nxt   = core_rstn_o;
    running_nxt     = running_o;
    halted_nxt      = halted_o;
    timeout_nxt     = timeout_o;
    halt_reason_nxt = halt_reason_o;
    cycle_cnt_nxt   = cycle_cnt_o;
    prev_pc_nxt     = prev_pc;
    pc_valid_nxt    = pc_valid;
    rep_cnt_nxt     = rep_cnt;
    pc_same         = 1'b0;

    case (state)
      RESET_HOLD: begin
        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_nxt     = RUN;
          core_rstn_nxt = 1'b1;
          running_nxt   = 1'b1;
        end
      end

      RUN: begin
        cycle_cnt_nxt = cycle_cnt_o + CNT_W'(1);
        prev_pc_nxt   = pc_i;
        pc_valid_nxt  = 1'b1;
        pc_same       = pc_valid && (pc_i == prev_pc);
        rep_cnt_nxt   = pc_same ? rep_cnt + REP_W'(1) : '0;

        // Halt sources outrank the timeout when both land on the same edge
        if (instr_i == INSTR_ECALL) begin
          state_nxt       = HALTED;
          running_nxt     = 1'b0;
          halted_nxt      = 1'b1;
          halt_reason_nxt = REASON_ECALL;
        end else if (instr_i == INSTR_EBREAK) begin
          state_nxt       = HALTED;
          running_nxt     = 1'b0;
          halted_nxt      = 1'b1;
          halt_reason_nxt = REASON_EBREAK;
        end else if (pc_same && (rep_cnt == REP_W'(HALT_REPEAT - 2))) begin
          state_nxt       = HALTED;
          running_nxt     = 1'b0;
          halted_nxt      = 1'b1;
          halt_reason_nxt = REASON_LOOP;
        end else if (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1)) begin
          state_nxt   = TIMEOUT;
          running_nxt = 1'b0;
          timeout_nxt = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed scenarios plus randomized programs, checked
// against a queue-based model of the run-control rules.
module tb_riscv_run_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RSTC  = 3;
  localparam int unsigned MAXC  = 8;
  localparam int unsigned HREP  = 4;
  localparam int unsigned CNT_W = 32;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             a_rstn;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             core_rstn_o, running_o, halted_o, timeout_o;
  logic [1:0]       halt_reason_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  riscv_run_ctrl #(
    .XLEN(XLEN), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .a_rstn(a_rstn), .pc_i(pc), .instr_i(instr),
    .core_rstn_o(core_rstn_o), .running_o(running_o), .halted_o(halted_o),
    .timeout_o(timeout_o), .halt_reason_o(halt_reason_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: flags plus the recent PC samples of the current run
  logic            m_core, m_running, m_halted, m_timeout;
  logic [1:0]      m_reason;
  int              m_cnt;
  logic [XLEN-1:0] m_hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".core_rstn"}, 64'(core_rstn_o), 64'(m_core));
    check({tag, ".running"},   64'(running_o),   64'(m_running));
    check({tag, ".halted"},    64'(halted_o),    64'(m_halted));
    check({tag, ".timeout"},   64'(timeout_o),   64'(m_timeout));
    check({tag, ".reason"},    64'(halt_reason_o), 64'(m_reason));
    check({tag, ".cycles"},    64'(cycle_cnt_o), 64'(m_cnt));
    check({tag, ".exclusive"}, 64'(halted_o & timeout_o), 64'(0));
  endtask

  task automatic model_reset();
    m_core = 1'b0; m_running = 1'b0; m_halted = 1'b0; m_timeout = 1'b0;
    m_reason = 2'b00; m_cnt = 0;
    m_hist.delete();
  endtask

  // One RUN cycle of the program-end rules, applied at a clock edge
  task automatic model_step(input logic [XLEN-1:0] p, input logic [31:0] i);
    int  n;
    bit  loop;
    if (!m_running) return;
    n = m_cnt + 1;
    m_hist.push_back(p);
    if (m_hist.size() > HREP) void'(m_hist.pop_front());
    loop = (m_hist.size() == HREP);
    foreach (m_hist[k]) if (m_hist[k] != m_hist[0]) loop = 0;
    if (i == ECALL)       begin m_halted = 1; m_reason = 2'b01; m_running = 0; end
    else if (i == EBREAK) begin m_halted = 1; m_reason = 2'b10; m_running = 0; end
    else if (loop)        begin m_halted = 1; m_reason = 2'b11; m_running = 0; end
    else if (n == MAXC)   begin m_timeout = 1; m_running = 0; end
    m_cnt = n;
  endtask

  // Assert reset between edges, check it took effect at once, then walk the hold window
  task automatic do_reset(input int low_ns, input string tag);
    a_rstn = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    #(low_ns);
    @(negedge clk);
    a_rstn = 1'b1;
    for (int k = 1; k <= RSTC; k++) begin
      @(posedge clk);
      #1;
      if (k == RSTC) begin m_core = 1'b1; m_running = 1'b1; end
      check_all({tag, ".hold"});
    end
  endtask

  task automatic cycle(input logic [XLEN-1:0] p, input logic [31:0] i, input string tag);
    pc = p;
    instr = i;
    @(posedge clk);
    model_step(p, i);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [XLEN-1:0] p;
    logic [31:0]     ins;
    int              len, r;

    a_rstn = 1'b0;
    pc = '0;
    instr = NOP;
    #2;

    // Reset stretch, then ECALL after five sequential fetches
    do_reset(15, "stretch");
    for (int c = 0; c < 5; c++) cycle(XLEN'(c * 4), NOP, "seq");
    cycle(XLEN'(20), ECALL, "ecall");
    check("ecall.cnt_is_6", 64'(cycle_cnt_o), 64'(6));

    // Terminal stickiness
    for (int c = 0; c < 20; c++)
      cycle(XLEN'($urandom), (c % 3 == 0) ? ECALL : $urandom, "sticky");

    // Self-loop on 0x0C
    do_reset(7, "loop_rst");
    cycle(XLEN'('h00), NOP, "loop");
    cycle(XLEN'('h04), NOP, "loop");
    cycle(XLEN'('h08), NOP, "loop");
    for (int c = 0; c < 4; c++) cycle(XLEN'('h0C), NOP, "loop");
    check("loop.reason_11", 64'(halt_reason_o), 64'(3));

    // EBREAK on the last budgeted cycle: halt beats timeout
    do_reset(11, "tie_rst");
    for (int c = 0; c < MAXC - 1; c++) cycle(XLEN'(c * 4), NOP, "tie");
    cycle(XLEN'(100), EBREAK, "tie.ebreak");
    check("tie.no_timeout", 64'(timeout_o), 64'(0));

    // Same program without EBREAK runs out of budget
    do_reset(9, "to_rst");
    for (int c = 0; c < MAXC + 3; c++) cycle(XLEN'(c * 4), NOP, "timeout");
    check("timeout.cnt_is_8", 64'(cycle_cnt_o), 64'(MAXC));

    // Reset mid-run at cycle 3, then a clean restart
    do_reset(13, "mid_rst");
    for (int c = 0; c < 3; c++) cycle(XLEN'(c * 4), NOP, "mid");
    do_reset(4, "mid_again");
    for (int c = 0; c < 4; c++) cycle(XLEN'(c * 4), NOP, "mid_restart");

    // Randomized programs with biased PC repeats and occasional ECALL/EBREAK
    for (int t = 0; t < 40; t++) begin
      do_reset(int'($urandom_range(3, 25)), "rand_rst");
      len = int'($urandom_range(2, 14));
      p = XLEN'($urandom_range(0, 3) * 4);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) >= 65) p = XLEN'($urandom_range(0, 3) * 4);
        r = int'($urandom_range(0, 99));
        ins = (r < 4) ? ECALL : (r < 8) ? EBREAK : $urandom;
        cycle(p, ins, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
